// File: rtl/alu_issue_ctrl.sv
// Issue controller driving a 32-bit combinational ALU: decodes RV32 ALU/branch ops,
// holds ALU operands through a multicycle window for MUL/DIVU and returns the result.
module alu_issue_ctrl #(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_out,
  input  logic        alu_carry,
  input  logic        alu_zero,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        branch_taken,
  output logic        illegal
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SEL_W = 4;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  localparam logic [SEL_W-1:0] SEL_ADD  = 4'b0000;
  localparam logic [SEL_W-1:0] SEL_SUB  = 4'b0001;
  localparam logic [SEL_W-1:0] SEL_MUL  = 4'b0010;
  localparam logic [SEL_W-1:0] SEL_DIVU = 4'b0011;
  localparam logic [SEL_W-1:0] SEL_SLL  = 4'b0100;
  localparam logic [SEL_W-1:0] SEL_SRL  = 4'b0101;
  localparam logic [SEL_W-1:0] SEL_AND  = 4'b1000;
  localparam logic [SEL_W-1:0] SEL_OR   = 4'b1001;
  localparam logic [SEL_W-1:0] SEL_XOR  = 4'b1010;
  localparam logic [SEL_W-1:0] SEL_CMPU = 4'b1110;
  localparam logic [SEL_W-1:0] SEL_EQ   = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  // How the registered ALU output is turned into res_data / branch_taken.
  typedef enum logic [3:0] {
    K_ALU, K_SLT, K_SLTU, K_DIVU, K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU
  } kind_t;

  state_t             state, state_nxt;
  kind_t              kind_q;
  logic [CNT_W-1:0]   cnt;

  logic [6:0]         opcode;
  logic [2:0]         f3;
  logic [6:0]         f7;
  logic [SEL_W-1:0]   dec_sel;
  kind_t              dec_kind;
  logic               dec_ill;
  logic               dec_multi;
  logic               dec_shift;

  logic               accept;
  logic               exec_last;
  logic               lt;
  logic               ltu;
  logic [XLEN-1:0]    res_nxt;
  logic               taken_nxt;

  logic               unused_bits;
  assign unused_bits = ^{alu_zero, instr[24:15], instr[11:7]};

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  // Instruction decode into ALU select, result kind and legality.
  always_comb begin : decode
    dec_sel   = SEL_ADD;
    dec_kind  = K_ALU;
    dec_ill   = 1'b0;
    dec_multi = 1'b0;
    dec_shift = 1'b0;
    if (opcode == OPC_B) begin
      case (f3)
        3'b000:  begin dec_sel = SEL_EQ;   dec_kind = K_BEQ;  end
        3'b001:  begin dec_sel = SEL_EQ;   dec_kind = K_BNE;  end
        3'b100:  begin dec_sel = SEL_SUB;  dec_kind = K_BLT;  end
        3'b101:  begin dec_sel = SEL_SUB;  dec_kind = K_BGE;  end
        3'b110:  begin dec_sel = SEL_CMPU; dec_kind = K_BLTU; end
        3'b111:  begin dec_sel = SEL_CMPU; dec_kind = K_BGEU; end
        default: dec_ill = 1'b1;
      endcase
    end else if (opcode == OPC_R && f7 == F7_MD) begin
      if (f3 == 3'b000) begin
        dec_sel   = SEL_MUL;
        dec_multi = 1'b1;
      end else if (f3 == 3'b101) begin
        dec_sel   = SEL_DIVU;
        dec_kind  = K_DIVU;
        dec_multi = 1'b1;
      end else begin
        dec_ill = 1'b1;
      end
    end else if (opcode == OPC_R && f7 == F7_ALT) begin
      if (f3 == 3'b000) dec_sel = SEL_SUB;
      else              dec_ill = 1'b1;
    end else if ((opcode == OPC_R && f7 == F7_BASE) || opcode == OPC_I) begin
      case (f3)
        3'b000: dec_ill = (opcode == OPC_I) && (f7 == F7_ALT);
        3'b001: begin
          dec_sel   = SEL_SLL;
          dec_shift = 1'b1;
          dec_ill   = (f7 != F7_BASE);
        end
        3'b010: begin dec_sel = SEL_SUB;  dec_kind = K_SLT;  end
        3'b011: begin dec_sel = SEL_CMPU; dec_kind = K_SLTU; end
        3'b100: dec_sel = SEL_XOR;
        3'b101: begin
          dec_sel   = SEL_SRL;
          dec_shift = 1'b1;
          dec_ill   = (f7 != F7_BASE);
        end
        3'b110: dec_sel = SEL_OR;
        3'b111: dec_sel = SEL_AND;
      endcase
    end else begin
      dec_ill = 1'b1;
    end
  end

  // State register; in_ready/res_valid are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == S_IDLE);
      res_valid <= (state_nxt == S_DONE);
    end
  end

  always_comb begin : next_state
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid) state_nxt = dec_ill ? S_DONE : S_EXEC;
      S_EXEC: if (cnt == '0) state_nxt = S_DONE;
      S_DONE: if (res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control strobes and result shaping from the registered ALU operands.
  always_comb begin : outputs
    accept    = (state == S_IDLE) && in_valid;
    exec_last = (state == S_EXEC) && (cnt == '0);
    ltu       = (alu_out == '0);
    lt        = (alu_a[XLEN-1] ^ alu_b[XLEN-1]) ? alu_a[XLEN-1] : alu_carry;
    res_nxt   = '0;
    taken_nxt = 1'b0;
    case (kind_q)
      K_ALU:   res_nxt   = alu_out;
      K_SLT:   res_nxt   = XLEN'(lt);
      K_SLTU:  res_nxt   = XLEN'(ltu);
      K_DIVU:  res_nxt   = (alu_b == '0) ? '1 : alu_out;
      K_BEQ:   taken_nxt = alu_out[0];
      K_BNE:   taken_nxt = ~alu_out[0];
      K_BLT:   taken_nxt = lt;
      K_BGE:   taken_nxt = ~lt;
      K_BLTU:  taken_nxt = ltu;
      K_BGEU:  taken_nxt = ~ltu;
      default: res_nxt   = '0;
    endcase
  end

  // Operand/select capture, EXEC countdown and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_sel      <= '0;
      kind_q       <= K_ALU;
      cnt          <= '0;
      res_data     <= '0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
    end else if (accept && dec_ill) begin
      res_data     <= '0;
      branch_taken <= 1'b0;
      illegal      <= 1'b1;
    end else if (accept) begin
      alu_a   <= op_a;
      alu_b   <= dec_shift ? {27'b0, op_b[4:0]} : op_b;
      alu_sel <= dec_sel;
      kind_q  <= dec_kind;
      cnt     <= dec_multi ? CNT_W'(MULDIV_CYCLES - 1) : '0;
    end else if (exec_last) begin
      res_data     <= res_nxt;
      branch_taken <= taken_nxt;
      illegal      <= 1'b0;
    end else if (state == S_EXEC) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule
